// File: rtl/simple_alu_arbiter_if.sv
// Bundles the requester stream ports and the shared ALU port of simple_alu_arbiter.
// The master modport is the arbiter's view; the slave modport is the environment's.
interface simple_alu_arbiter_if #(
   parameter int NumReq    = 4,
   parameter int DataWidth = 64
);
   logic [NumReq*DataWidth-1:0] req_a_i;
   logic [NumReq*DataWidth-1:0] req_b_i;
   logic [NumReq*2-1:0]         req_op_i;
   logic [NumReq-1:0]           req_valid_i;
   logic [NumReq-1:0]           req_ready_o;
   logic [DataWidth-1:0]        resp_data_o;
   logic [NumReq-1:0]           resp_valid_o;
   logic [NumReq-1:0]           resp_ready_i;
   logic [DataWidth-1:0]        alu_a_o;
   logic [DataWidth-1:0]        alu_b_o;
   logic                        alu_a_valid_o;
   logic                        alu_b_valid_o;
   logic                        alu_a_ready_i;
   logic                        alu_b_ready_i;
   logic [1:0]                  alu_config_o;
   logic [DataWidth-1:0]        alu_result_i;
   logic                        alu_result_valid_i;
   logic                        alu_result_ready_o;

   modport master (
      input  req_a_i, req_b_i, req_op_i, req_valid_i, resp_ready_i,
      input  alu_a_ready_i, alu_b_ready_i, alu_result_i, alu_result_valid_i,
      output req_ready_o, resp_data_o, resp_valid_o,
      output alu_a_o, alu_b_o, alu_a_valid_o, alu_b_valid_o, alu_config_o, alu_result_ready_o
   );

   modport slave (
      output req_a_i, req_b_i, req_op_i, req_valid_i, resp_ready_i,
      output alu_a_ready_i, alu_b_ready_i, alu_result_i, alu_result_valid_i,
      input  req_ready_o, resp_data_o, resp_valid_o,
      input  alu_a_o, alu_b_o, alu_a_valid_o, alu_b_valid_o, alu_config_o, alu_result_ready_o
   );
endinterface

// File: rtl/simple_alu_arbiter.sv
// Round-robin arbiter sharing one ALU between NumReq requesters, one operation in flight.
// Sequence per operation: IDLE (grant) -> ISSUE (operands) -> WAIT (result) -> RESP (return).
module simple_alu_arbiter #(
   parameter int NumReq    = 4,
   parameter int DataWidth = 64,
   parameter int CntWidth  = 32
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   simple_alu_arbiter_if.master      bus,
   output logic                      busy_o,
   output logic [$clog2(NumReq)-1:0] grant_id_o,
   output logic [CntWidth-1:0]       ops_done_o
);
   localparam int IdxW = $clog2(NumReq);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_e;

   state_e               state_q, state_d;
   logic [IdxW-1:0]      ptr_q, ptr_d;
   logic [IdxW-1:0]      grant_q, grant_d;
   logic [DataWidth-1:0] a_q, a_d;
   logic [DataWidth-1:0] b_q, b_d;
   logic [1:0]           op_q, op_d;
   logic [DataWidth-1:0] res_q, res_d;
   logic                 alu_valid_q, alu_valid_d;
   logic                 res_rdy_q, res_rdy_d;
   logic [NumReq-1:0]    resp_valid_q, resp_valid_d;
   logic                 busy_q, busy_d;
   logic [CntWidth-1:0]  cnt_q, cnt_d;

   logic [IdxW-1:0]      cand [NumReq];
   logic                 win_found;
   logic [IdxW-1:0]      win_idx;

   // Round-robin search starting at the pointer; first valid requester wins.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      for (int i = 0; i < NumReq; i++) begin
         cand[i]   = IdxW'((int'(ptr_q) + i) % NumReq);
         win_idx   = (!win_found && bus.req_valid_i[cand[i]]) ? cand[i] : win_idx;
         win_found = win_found | bus.req_valid_i[cand[i]];
      end
   end

   // Acceptance is only offered while idle and out of reset.
   assign bus.req_ready_o = (state_q == IDLE && win_found && !rst_i)
                            ? (NumReq'(1) << win_idx) : '0;

   // Next-state and next-output computation for the operation sequencer.
   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      grant_d      = grant_q;
      a_d          = a_q;
      b_d          = b_q;
      op_d         = op_q;
      res_d        = res_q;
      alu_valid_d  = alu_valid_q;
      res_rdy_d    = res_rdy_q;
      resp_valid_d = resp_valid_q;
      busy_d       = busy_q;
      cnt_d        = cnt_q;
      case (state_q)
         IDLE: begin
            // Stray ALU results are drained while idle.
            res_rdy_d = 1'b1;
            if (win_found) begin
               a_d         = bus.req_a_i[int'(win_idx)*DataWidth +: DataWidth];
               b_d         = bus.req_b_i[int'(win_idx)*DataWidth +: DataWidth];
               op_d        = bus.req_op_i[int'(win_idx)*2 +: 2];
               grant_d     = win_idx;
               ptr_d       = (win_idx == IdxW'(NumReq - 1)) ? '0 : win_idx + 1'b1;
               state_d     = ISSUE;
               alu_valid_d = 1'b1;
               res_rdy_d   = 1'b0;
               busy_d      = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         ISSUE: begin
            if (bus.alu_a_ready_i && bus.alu_b_ready_i) begin
               state_d     = WAIT;
               alu_valid_d = 1'b0;
               res_rdy_d   = 1'b1;
            end else begin
               state_d = ISSUE;
            end
         end
         WAIT: begin
            if (bus.alu_result_valid_i) begin
               res_d        = bus.alu_result_i;
               state_d      = RESP;
               res_rdy_d    = 1'b0;
               resp_valid_d = NumReq'(1) << grant_q;
            end else begin
               state_d = WAIT;
            end
         end
         RESP: begin
            if (bus.resp_ready_i[grant_q]) begin
               state_d      = IDLE;
               resp_valid_d = '0;
               res_d        = '0;
               busy_d       = 1'b0;
               res_rdy_d    = 1'b1;
               cnt_d        = cnt_q + CntWidth'(1);
            end else begin
               state_d = RESP;
            end
         end
         default: begin
            state_d      = IDLE;
            alu_valid_d  = 1'b0;
            res_rdy_d    = 1'b0;
            resp_valid_d = '0;
            busy_d       = 1'b0;
         end
      endcase
   end

   // State and registered outputs; reset drops any operation in flight.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         ptr_q        <= '0;
         grant_q      <= '0;
         a_q          <= '0;
         b_q          <= '0;
         op_q         <= 2'd0;
         res_q        <= '0;
         alu_valid_q  <= 1'b0;
         res_rdy_q    <= 1'b0;
         resp_valid_q <= '0;
         busy_q       <= 1'b0;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         grant_q      <= grant_d;
         a_q          <= a_d;
         b_q          <= b_d;
         op_q         <= op_d;
         res_q        <= res_d;
         alu_valid_q  <= alu_valid_d;
         res_rdy_q    <= res_rdy_d;
         resp_valid_q <= resp_valid_d;
         busy_q       <= busy_d;
         cnt_q        <= cnt_d;
      end
   end

   assign bus.alu_a_o            = a_q;
   assign bus.alu_b_o            = b_q;
   assign bus.alu_config_o       = op_q;
   assign bus.alu_a_valid_o      = alu_valid_q;
   assign bus.alu_b_valid_o      = alu_valid_q;
   assign bus.alu_result_ready_o = res_rdy_q;
   assign bus.resp_data_o        = res_q;
   assign bus.resp_valid_o       = resp_valid_q;
   assign busy_o                 = busy_q;
   assign grant_id_o             = grant_q;
   assign ops_done_o             = cnt_q;
endmodule
